procfixcba_biquad: RTL and testbench

// - Streaming signed fixed-point processing core. Pulls one sample per frame from an

---
 rtl/procfixcba_biquad.sv | 174 +++++++++++++++++
 tb/tb_procfixcba_biquad.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/procfixcba_biquad.sv
// Streaming direct-form-I biquad with one shared multiplier.
// Each 7-cycle frame requests one sample, runs five multiply-accumulate
// steps and emits one saturated result.
module procfixcba_biquad #(
  parameter int W    = 31,
  parameter int CW   = 18,
  parameter int FRAC = 14,
  parameter int B0   = 16384,
  parameter int B1   = 0,
  parameter int B2   = 0,
  parameter int A1   = 0,
  parameter int A2   = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in,
  output logic [W-1:0] io_out,
  output logic [1:0]   req_in,
  output logic [1:0]   out_en
);

  localparam int AW = 2 * W + CW;
  localparam int PW = W + CW;

  localparam logic signed [CW-1:0] B0_C = CW'(B0);
  localparam logic signed [CW-1:0] B1_C = CW'(B1);
  localparam logic signed [CW-1:0] B2_C = CW'(B2);
  localparam logic signed [CW-1:0] A1_C = CW'(A1);
  localparam logic signed [CW-1:0] A2_C = CW'(A2);

  typedef enum logic [2:0] {
    S_REQ = 3'd0,
    S_M0  = 3'd1,
    S_M1  = 3'd2,
    S_M2  = 3'd3,
    S_M3  = 3'd4,
    S_M4  = 3'd5,
    S_OUT = 3'd6
  } state_t;

  state_t                 state_r;
  logic                   req_r;
  logic                   out_en_r;
  logic signed [W-1:0]    io_out_r;
  logic signed [AW-1:0]   acc_r;
  logic signed [W-1:0]    x0_r;
  logic signed [W-1:0]    x1_r;
  logic signed [W-1:0]    x2_r;
  logic signed [W-1:0]    y1_r;
  logic signed [W-1:0]    y2_r;

  logic signed [CW-1:0]   coef_s;
  logic signed [W-1:0]    data_s;
  logic signed [PW-1:0]   prod_s;
  logic signed [AW-1:0]   prod_ext_s;
  logic signed [AW-1:0]   acc_next_s;
  logic signed [AW-1:0]   shifted_s;

  // Clamp a wide signed value into the W-bit two's complement range.
  function automatic logic signed [W-1:0] sat_fn(input logic signed [AW-1:0] v);
    logic signed [W-1:0] r;
    if ((&v[AW-1:W-1]) || (~|v[AW-1:W-1])) begin
      r = v[W-1:0];
    end else if (v[AW-1]) begin
      r = {1'b1, {(W-1){1'b0}}};
    end else begin
      r = {1'b0, {(W-1){1'b1}}};
    end
    return r;
  endfunction

  // Select the coefficient/data pair for the shared multiplier.
  always_comb begin
    coef_s = B0_C;
    data_s = x0_r;
    case (state_r)
      S_M0:    begin coef_s = B0_C; data_s = x0_r; end
      S_M1:    begin coef_s = B1_C; data_s = x1_r; end
      S_M2:    begin coef_s = B2_C; data_s = x2_r; end
      S_M3:    begin coef_s = A1_C; data_s = y1_r; end
      S_M4:    begin coef_s = A2_C; data_s = y2_r; end
      default: begin coef_s = B0_C; data_s = x0_r; end
    endcase
  end

  // Shared signed multiplier, operands widened so the product is exact.
  assign prod_s     = PW'(coef_s) * PW'(data_s);
  assign prod_ext_s = AW'(prod_s);

  // Next accumulator value: load, add feed-forward, subtract feedback.
  always_comb begin
    acc_next_s = acc_r;
    case (state_r)
      S_M0:       acc_next_s = prod_ext_s;
      S_M1, S_M2: acc_next_s = acc_r + prod_ext_s;
      S_M3, S_M4: acc_next_s = acc_r - prod_ext_s;
      default:    acc_next_s = acc_r;
    endcase
  end

  // Arithmetic shift floors toward minus infinity.
  assign shifted_s = acc_next_s >>> FRAC;

  // Frame sequencer, datapath registers and registered strobes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r  <= S_REQ;
      req_r    <= 1'b0;
      out_en_r <= 1'b0;
      io_out_r <= '0;
      acc_r    <= '0;
      x0_r     <= '0;
      x1_r     <= '0;
      x2_r     <= '0;
      y1_r     <= '0;
      y2_r     <= '0;
    end else begin
      case (state_r)
        S_REQ: begin
          // req_r low here only in the first cycle after reset release.
          if (req_r) begin
            x0_r    <= $signed(in);
            req_r   <= 1'b0;
            state_r <= S_M0;
          end else begin
            req_r   <= 1'b1;
          end
        end
        S_M0: begin
          acc_r   <= acc_next_s;
          state_r <= S_M1;
        end
        S_M1: begin
          acc_r   <= acc_next_s;
          state_r <= S_M2;
        end
        S_M2: begin
          acc_r   <= acc_next_s;
          state_r <= S_M3;
        end
        S_M3: begin
          acc_r   <= acc_next_s;
          state_r <= S_M4;
        end
        S_M4: begin
          // Result is presented during S_OUT, so it is registered here.
          acc_r    <= acc_next_s;
          io_out_r <= sat_fn(shifted_s);
          out_en_r <= 1'b1;
          state_r  <= S_OUT;
        end
        S_OUT: begin
          out_en_r <= 1'b0;
          req_r    <= 1'b1;
          x2_r     <= x1_r;
          x1_r     <= x0_r;
          y2_r     <= y1_r;
          y1_r     <= io_out_r;
          state_r  <= S_REQ;
        end
        default: begin
          req_r    <= 1'b0;
          out_en_r <= 1'b0;
          state_r  <= S_REQ;
        end
      endcase
    end
  end

  assign io_out = io_out_r;
  assign req_in = {1'b0, req_r};
  assign out_en = {1'b0, out_en_r};

endmodule

// File: tb/tb_procfixcba_biquad.sv
// Scoreboard bench: five biquad instances with different coefficient sets,
// exercised one after another; expected outputs queued on each request.
module tb_procfixcba_biquad;

  localparam int W = 31;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_a [5];
  logic [W-1:0] in_a  [5];
  wire  [W-1:0] out_w [5];
  wire  [1:0]   req_w [5];
  wire  [1:0]   en_w  [5];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  logic signed [31:0] exp_q [$];

  // Free-running cycle counter for latency and period checks.
  always @(posedge clk) cyc <= cyc + 1;

  procfixcba_biquad u_pass (
    .clk(clk), .rst(rst_a[0]), .in(in_a[0]), .io_out(out_w[0]),
    .req_in(req_w[0]), .out_en(en_w[0]));

  procfixcba_biquad #(.B0(8192), .B1(8192)) u_ff (
    .clk(clk), .rst(rst_a[1]), .in(in_a[1]), .io_out(out_w[1]),
    .req_in(req_w[1]), .out_en(en_w[1]));

  procfixcba_biquad #(.A1(-8192)) u_fb (
    .clk(clk), .rst(rst_a[2]), .in(in_a[2]), .io_out(out_w[2]),
    .req_in(req_w[2]), .out_en(en_w[2]));

  procfixcba_biquad #(.B0(8192)) u_rnd (
    .clk(clk), .rst(rst_a[3]), .in(in_a[3]), .io_out(out_w[3]),
    .req_in(req_w[3]), .out_en(en_w[3]));

  procfixcba_biquad #(.B0(32767)) u_sat (
    .clk(clk), .rst(rst_a[4]), .in(in_a[4]), .io_out(out_w[4]),
    .req_in(req_w[4]), .out_en(en_w[4]));

  task automatic check_val(input string tag, input logic signed [31:0] obs,
                           input logic signed [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic signed [31:0] out_sx(input int ln);
    logic [W-1:0] v;
    v = out_w[ln];
    return {v[W-1], v};
  endfunction

  // Release one lane from reset and stream samples until n results are seen.
  task automatic run_lane(input int ln, input int s[4], input int e[4], input int n);
    int   idx;
    int   got;
    int   last_req;
    int   budget;
    logic adv;
    idx      = 0;
    got      = 0;
    last_req = -1;
    budget   = 0;
    in_a[ln] = W'(s[0]);
    @(negedge clk);
    rst_a[ln] = 1'b1;
    while (got < n && budget < 200) begin
      @(negedge clk);
      budget++;
      adv = 1'b0;
      check_val($sformatf("L%0d bit1", ln), {30'd0, req_w[ln][1], en_w[ln][1]}, 32'sd0);
      check_val($sformatf("L%0d req_en_excl", ln), {31'd0, req_w[ln][0] & en_w[ln][0]}, 32'sd0);
      if (req_w[ln][0]) begin
        if (last_req >= 0) check_val($sformatf("L%0d req_period", ln), cyc - last_req, 32'sd7);
        last_req = cyc;
        if (idx < n) exp_q.push_back(e[idx]);
        adv = 1'b1;
      end
      if (en_w[ln][0]) begin
        check_val($sformatf("L%0d latency", ln), cyc - last_req, 32'sd6);
        if (exp_q.size() == 0) begin
          check_val($sformatf("L%0d spurious_out", ln), out_sx(ln), 32'sd0 - 32'sd1);
        end else begin
          check_val($sformatf("L%0d io_out", ln), out_sx(ln), exp_q.pop_front());
        end
        got++;
      end
      @(posedge clk);
      #1;
      if (adv) begin
        idx++;
        in_a[ln] = (idx < 4) ? W'(s[idx]) : '0;
      end
    end
    if (got < n) check_val($sformatf("L%0d timeout", ln), got, n);
  endtask

  initial begin
    int s0[4] = '{100, -7, 0, 0};
    int e0[4] = '{100, -7, 0, 0};
    int s1[4] = '{100, 200, 300, 0};
    int e1[4] = '{50, 150, 250, 0};
    int s2[4] = '{1000, 0, 0, 0};
    int e2[4] = '{1000, 500, 250, 125};
    int s3[4] = '{-3, 3, 0, 0};
    int e3[4] = '{-2, 1, 0, 0};
    int s4[4] = '{1073741823, -1073741824, 0, 0};
    int e4[4] = '{1073741823, -1073741824, 0, 0};

    for (int i = 0; i < 5; i++) begin
      rst_a[i] = 1'b0;
      in_a[i]  = '0;
    end
    repeat (3) @(negedge clk);
    check_val("reset io_out", out_sx(0), 32'sd0);
    check_val("reset req_in", {30'd0, req_w[0]}, 32'sd0);
    check_val("reset out_en", {30'd0, en_w[0]}, 32'sd0);

    run_lane(0, s0, e0, 3);
    rst_a[0] = 1'b0;
    run_lane(1, s1, e1, 3);
    rst_a[1] = 1'b0;
    run_lane(2, s2, e2, 4);
    rst_a[2] = 1'b0;
    exp_q.delete();
    run_lane(3, s3, e3, 2);
    rst_a[3] = 1'b0;
    run_lane(4, s4, e4, 2);
    rst_a[4] = 1'b0;

    // Two frames of the feedback case, then reset in the middle of S_M2.
    exp_q.delete();
    repeat (2) @(negedge clk);
    run_lane(2, s2, e2, 2);
    @(negedge clk);
    check_val("abort req_in", {30'd0, req_w[2]}, 32'sd1);
    repeat (3) @(negedge clk);
    rst_a[2] = 1'b0;
    #1;
    check_val("abort io_out", out_sx(2), 32'sd0);
    check_val("abort req_in0", {30'd0, req_w[2]}, 32'sd0);
    check_val("abort out_en", {30'd0, en_w[2]}, 32'sd0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check_val("abort no_out_en", {30'd0, en_w[2]}, 32'sd0);
    end
    exp_q.delete();
    run_lane(2, s2, e2, 3);
    rst_a[2] = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
